// File: rtl/usr_pkg.sv
// rtl/usr_pkg.sv - mode and FSM state encodings shared by the universal shift register
package usr_pkg;

   localparam int MODE_W = 3;

   localparam logic [MODE_W-1:0] MODE_HOLD = 3'd0;
   localparam logic [MODE_W-1:0] MODE_SHR  = 3'd1;
   localparam logic [MODE_W-1:0] MODE_SHL  = 3'd2;
   localparam logic [MODE_W-1:0] MODE_ROR  = 3'd3;
   localparam logic [MODE_W-1:0] MODE_ROL  = 3'd4;
   localparam logic [MODE_W-1:0] MODE_LOAD = 3'd5;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } usr_state_e;

   // Only shifts and rotates may be repeated autonomously by a burst.
   function automatic logic is_shift_mode(input logic [MODE_W-1:0] m);
      return (m == MODE_SHR) || (m == MODE_SHL) || (m == MODE_ROR) || (m == MODE_ROL);
   endfunction

endpackage

// File: rtl/usr_burst_ctrl.sv
// rtl/usr_burst_ctrl.sv - IDLE/BURST sequencer: down-counts a latched shift op, yields busy/done
module usr_burst_ctrl
   import usr_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [MODE_W-1:0] mode_i,
   input  logic              start_i,
   input  logic [CNT_W-1:0]  count_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [MODE_W-1:0] op_o
);

   usr_state_e        state_q, state_d;
   logic [CNT_W-1:0]  rem_q, rem_d;
   logic [MODE_W-1:0] op_q, op_d;
   logic              done_q, done_d;
   logic              accept;

   assign accept = (state_q == ST_IDLE) && start_i && is_shift_mode(mode_i)
                   && (count_i != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         rem_q   <= '0;
         op_q    <= MODE_HOLD;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         op_q    <= op_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      op_d    = op_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_BURST;
               rem_d   = count_i;
               op_d    = mode_i;
            end
         end
         ST_BURST: begin
            rem_d = rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // The accept edge leaves q untouched, so the datapath sees HOLD then.
   always_comb begin
      busy_o = (state_q == ST_BURST);
      done_o = done_q;
      if (state_q == ST_BURST) begin
         op_o = op_q;
      end else if (accept) begin
         op_o = MODE_HOLD;
      end else begin
         op_o = mode_i;
      end
   end

endmodule

// File: rtl/univ_shift_register.sv
// rtl/univ_shift_register.sv - universal shift register: shift/rotate/load with counted burst mode
module univ_shift_register
   import usr_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [MODE_W-1:0] mode,
   input  logic              serial_in_r,
   input  logic              serial_in_l,
   input  logic [WIDTH-1:0]  data_in,
   input  logic              start,
   input  logic [CNT_W-1:0]  count,
   output logic [WIDTH-1:0]  q,
   output logic              serial_out_r,
   output logic              serial_out_l,
   output logic              busy,
   output logic              done
);

   logic [WIDTH-1:0]  q_q, q_d;
   logic [MODE_W-1:0] op;

   usr_burst_ctrl #(.CNT_W(CNT_W)) u_ctrl (
      .clk    (clk),
      .rst    (rst),
      .mode_i (mode),
      .start_i(start),
      .count_i(count),
      .busy_o (busy),
      .done_o (done),
      .op_o   (op)
   );

   // Reserved encodings fall through to HOLD.
   always_comb begin
      q_d = q_q;
      case (op)
         MODE_SHR:  q_d = {serial_in_r, q_q[WIDTH-1:1]};
         MODE_SHL:  q_d = {q_q[WIDTH-2:0], serial_in_l};
         MODE_ROR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
         MODE_ROL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
         MODE_LOAD: q_d = data_in;
         default:   q_d = q_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q            = q_q;
   assign serial_out_r = q_q[0];
   assign serial_out_l = q_q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_register.sv
// tb/tb_univ_shift_register.sv - directed table-driven bench for univ_shift_register
module tb_univ_shift_register;

   logic       clk;
   logic       rst;
   logic [2:0] mode;
   logic       serial_in_r;
   logic       serial_in_l;
   logic [7:0] data_in8;
   logic [3:0] data_in4;
   logic       start;
   logic [7:0] count;

   logic [7:0] q8;
   logic       sor8, sol8, busy8, done8;
   logic [3:0] q4;
   logic       sor4, sol4, busy4, done4;

   int checks   = 0;
   int failures = 0;

   univ_shift_register #(.WIDTH(8), .CNT_W(8)) dut8 (
      .clk(clk), .rst(rst), .mode(mode), .serial_in_r(serial_in_r),
      .serial_in_l(serial_in_l), .data_in(data_in8), .start(start), .count(count),
      .q(q8), .serial_out_r(sor8), .serial_out_l(sol8), .busy(busy8), .done(done8)
   );

   univ_shift_register #(.WIDTH(4), .CNT_W(8)) dut4 (
      .clk(clk), .rst(rst), .mode(mode), .serial_in_r(serial_in_r),
      .serial_in_l(serial_in_l), .data_in(data_in4), .start(start), .count(count),
      .q(q4), .serial_out_r(sor4), .serial_out_l(sol4), .busy(busy4), .done(done4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [2:0] HOLD = 3'd0, SHR = 3'd1, SHL = 3'd2, ROR = 3'd3,
                          ROL = 3'd4, LOAD = 3'd5, RSV = 3'd6;

   typedef struct {
      logic [2:0] mode;
      logic       sr;
      logic       sl;
      logic [7:0] data;
      logic       start;
      logic [7:0] cnt;
      logic [7:0] exp_q;
      logic       exp_busy;
      logic       exp_done;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [2:0] m, input logic sr, input logic sl,
                      input logic [7:0] d, input logic st, input logic [7:0] c,
                      input logic [7:0] eq, input logic eb, input logic ed);
      vec_t v;
      v.mode = m; v.sr = sr; v.sl = sl; v.data = d; v.start = st; v.cnt = c;
      v.exp_q = eq; v.exp_busy = eb; v.exp_done = ed;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic [2:0] m, input logic sr, input logic sl,
                        input logic [7:0] d, input logic st, input logic [7:0] c);
      @(negedge clk);
      rst = r; mode = m; serial_in_r = sr; serial_in_l = sl;
      data_in8 = d; data_in4 = d[3:0]; start = st; count = c;
      @(posedge clk);
      #1;
   endtask

   task automatic check8(input string name, input logic [7:0] eq, input logic eb, input logic ed);
      check({name, ".q"}, 32'(q8), 32'(eq));
      check({name, ".busy"}, 32'(busy8), 32'(eb));
      check({name, ".done"}, 32'(done8), 32'(ed));
   endtask

   initial begin
      rst = 1'b1; mode = HOLD; serial_in_r = 1'b0; serial_in_l = 1'b0;
      data_in8 = '0; data_in4 = '0; start = 1'b0; count = '0;

      // Reset state and the 4-bit shift-right sequence.
      drive(1, SHR, 1, 0, 8'hFF, 1, 8'd3);
      check("rst.q4", 32'(q4), 32'h0);
      check("rst.busy4", 32'(busy4), 32'h0);
      check("rst.done4", 32'(done4), 32'h0);
      check8("rst8", 8'h00, 0, 0);
      drive(0, SHR, 1, 0, 8'h00, 0, 8'd0);
      check("shr4.1", 32'(q4), 32'h8);
      check("shr4.1.sol", 32'(sol4), 32'h1);
      drive(0, SHR, 0, 0, 8'h00, 0, 8'd0);
      check("shr4.2", 32'(q4), 32'h4);
      drive(0, SHR, 0, 0, 8'h00, 0, 8'd0);
      check("shr4.3", 32'(q4), 32'h2);
      check("shr4.3.sor", 32'(sor4), 32'h0);
      drive(0, SHR, 0, 0, 8'h00, 0, 8'd0);
      check("shr4.4", 32'(q4), 32'h1);
      check("shr4.4.sor", 32'(sor4), 32'h1);

      // Direct-mode rotates and shifts.
      add(LOAD, 0, 0, 8'hA5, 0, 0, 8'hA5, 0, 0);
      add(ROL,  0, 0, 8'h00, 0, 0, 8'h4B, 0, 0);
      add(ROL,  0, 0, 8'h00, 0, 0, 8'h96, 0, 0);
      add(ROL,  0, 0, 8'h00, 0, 0, 8'h2D, 0, 0);
      add(ROL,  0, 0, 8'h00, 0, 0, 8'h5A, 0, 0);
      add(ROL,  0, 0, 8'h00, 0, 0, 8'hB4, 0, 0);
      add(ROL,  0, 0, 8'h00, 0, 0, 8'h69, 0, 0);
      add(ROL,  0, 0, 8'h00, 0, 0, 8'hD2, 0, 0);
      add(ROL,  0, 0, 8'h00, 0, 0, 8'hA5, 0, 0);
      add(ROR,  0, 0, 8'h00, 0, 0, 8'hD2, 0, 0);
      add(SHL,  0, 1, 8'h00, 0, 0, 8'hA5, 0, 0);
      add(RSV,  1, 1, 8'h00, 0, 0, 8'hA5, 0, 0);
      // ROR burst of 3.
      add(LOAD, 0, 0, 8'h81, 0, 0, 8'h81, 0, 0);
      add(ROR,  0, 0, 8'h00, 1, 3, 8'h81, 1, 0);
      add(HOLD, 0, 0, 8'h00, 0, 0, 8'hC0, 1, 0);
      add(HOLD, 0, 0, 8'h00, 0, 0, 8'h60, 1, 0);
      add(HOLD, 0, 0, 8'h00, 0, 0, 8'h30, 0, 1);
      add(HOLD, 0, 0, 8'h00, 0, 0, 8'h30, 0, 0);
      // SHL burst of 10 > WIDTH, ones fill.
      add(SHL,  0, 1, 8'h00, 1, 10, 8'h30, 1, 0);
      add(HOLD, 0, 1, 8'h00, 0, 0, 8'h61, 1, 0);
      add(HOLD, 0, 1, 8'h00, 0, 0, 8'hC3, 1, 0);
      add(HOLD, 0, 1, 8'h00, 0, 0, 8'h87, 1, 0);
      add(HOLD, 0, 1, 8'h00, 0, 0, 8'h0F, 1, 0);
      add(HOLD, 0, 1, 8'h00, 0, 0, 8'h1F, 1, 0);
      add(HOLD, 0, 1, 8'h00, 0, 0, 8'h3F, 1, 0);
      add(HOLD, 0, 1, 8'h00, 0, 0, 8'h7F, 1, 0);
      add(HOLD, 0, 1, 8'h00, 0, 0, 8'hFF, 1, 0);
      add(HOLD, 0, 1, 8'h00, 0, 0, 8'hFF, 1, 0);
      add(HOLD, 0, 1, 8'h00, 0, 0, 8'hFF, 0, 1);
      // Inputs ignored mid-burst, back-to-back start, rejected starts.
      add(LOAD, 0, 0, 8'h0F, 0, 0, 8'h0F, 0, 0);
      add(ROL,  0, 0, 8'h00, 1, 2, 8'h0F, 1, 0);
      add(LOAD, 0, 0, 8'hFF, 1, 7, 8'h1E, 1, 0);
      add(LOAD, 0, 0, 8'hFF, 1, 7, 8'h3C, 0, 1);
      add(ROR,  0, 0, 8'h00, 1, 1, 8'h3C, 1, 0);
      add(HOLD, 0, 0, 8'h00, 0, 0, 8'h1E, 0, 1);
      add(SHR,  0, 0, 8'h00, 1, 0, 8'h0F, 0, 0);
      add(LOAD, 0, 0, 8'hAA, 1, 5, 8'hAA, 0, 0);
      add(HOLD, 0, 0, 8'h00, 0, 0, 8'hAA, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(0, vecs[i].mode, vecs[i].sr, vecs[i].sl, vecs[i].data, vecs[i].start,
               vecs[i].cnt);
         check($sformatf("vec%0d.q", i), 32'(q8), 32'(vecs[i].exp_q));
         check($sformatf("vec%0d.busy", i), 32'(busy8), 32'(vecs[i].exp_busy));
         check($sformatf("vec%0d.done", i), 32'(done8), 32'(vecs[i].exp_done));
         check($sformatf("vec%0d.sor", i), 32'(sor8), 32'(vecs[i].exp_q[0]));
         check($sformatf("vec%0d.sol", i), 32'(sol8), 32'(vecs[i].exp_q[7]));
      end

      // Reset lands on the second shift of a 5-shift burst.
      drive(0, LOAD, 0, 0, 8'h55, 0, 0);
      check8("abort.load", 8'h55, 0, 0);
      drive(0, SHR, 1, 0, 8'h00, 1, 5);
      check8("abort.accept", 8'h55, 1, 0);
      drive(0, HOLD, 1, 0, 8'h00, 0, 0);
      check8("abort.shift1", 8'hAA, 1, 0);
      drive(1, HOLD, 1, 0, 8'h00, 0, 0);
      check8("abort.rst", 8'h00, 0, 0);
      for (int i = 0; i < 5; i++) begin
         drive(0, HOLD, 1, 0, 8'h00, 0, 0);
         check8($sformatf("abort.quiet%0d", i), 8'h00, 0, 0);
      end
      drive(0, LOAD, 0, 0, 8'h01, 0, 0);
      drive(0, SHL, 0, 0, 8'h00, 1, 1);
      check8("post.accept", 8'h01, 1, 0);
      drive(0, HOLD, 0, 0, 8'h00, 0, 0);
      check8("post.shift", 8'h02, 0, 1);
      drive(0, HOLD, 0, 0, 8'h00, 0, 0);
      check8("post.idle", 8'h02, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
